// File: rtl/calc_ctrl.sv
// Calculator control unit: button synchronizer and edge detector, operand latch,
// and an FSM that sequences the ALU or divider and holds the result for the display.
module calc_ctrl #(
    parameter int BITS        = 8,
    parameter int DIV_TIMEOUT = 32
) (
    input  logic                clk16M,
    input  logic                rst,
    input  logic [BITS-1:0]     sw,
    input  logic [3:0]          bt,
    output logic [BITS/2-1:0]   a_op,
    output logic [BITS/2-1:0]   b_op,
    output logic [3:0]          op_sel,
    output logic                div_start,
    input  logic                div_done,
    input  logic                div_err,
    input  logic                sub_err,
    input  logic [BITS-1:0]     mux_result,
    output logic [BITS-1:0]     result,
    output logic                busy,
    output logic                err,
    output logic                valid
);

    localparam int HW = BITS / 2;
    localparam int CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LATCH, EXEC, WAIT_DIV, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      bt_s1, bt_s2, bt_d;
    logic [1:0]      arm_cnt;
    logic [3:0]      press, press_1h;
    logic [3:0]      op_rec;
    logic [CW-1:0]   tmo_cnt;

    // Edge detection stays disarmed until the synchronizer has refilled after
    // reset, so a button held through reset release does not look like a press.
    always_ff @(posedge clk16M) begin
        if (rst) begin
            bt_s1   <= '0;
            bt_s2   <= '0;
            bt_d    <= '0;
            arm_cnt <= '0;
        end else begin
            bt_s1 <= bt;
            bt_s2 <= bt_s1;
            bt_d  <= bt_s2;
            if (arm_cnt != 2'd3)
                arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign press    = (arm_cnt == 2'd3) ? (bt_s2 & ~bt_d) : 4'b0000;
    assign press_1h = press & (~press + 4'd1);

    always_ff @(posedge clk16M) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE:     if (|press) state_nxt = LATCH;
            LATCH: begin
                if (op_rec[3]) begin
                    div_start = 1'b1;
                    state_nxt = WAIT_DIV;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC:     state_nxt = DONE;
            WAIT_DIV: if (div_done || tmo_cnt == TMO_LAST) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk16M) begin
        if (rst) begin
            a_op    <= '0;
            b_op    <= '0;
            op_sel  <= '0;
            op_rec  <= '0;
            result  <= '0;
            err     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            valid <= (state_nxt == DONE);
            busy  <= (state_nxt != IDLE);
            case (state)
                IDLE: if (|press) op_rec <= press_1h;
                LATCH: begin
                    a_op    <= sw[BITS-1:HW];
                    b_op    <= sw[HW-1:0];
                    op_sel  <= op_rec;
                    tmo_cnt <= '0;
                end
                EXEC: begin
                    if (op_sel[1] && sub_err) begin
                        result <= '1;
                        err    <= 1'b1;
                    end else begin
                        result <= mux_result;
                        err    <= 1'b0;
                    end
                end
                WAIT_DIV: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // div_done wins over a timeout landing in the same cycle
                    if (div_done) begin
                        result <= div_err ? '1 : mux_result;
                        err    <= div_err;
                    end else if (tmo_cnt == TMO_LAST) begin
                        result <= '1;
                        err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: a vector table of operations with hand-computed
// results, plus sequences for reset, busy-ignore and abort-in-WAIT_DIV cases.
module tb_calc_ctrl;

    logic       clk16M = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [3:0] bt;
    logic [3:0] a_op, b_op;
    logic [3:0] op_sel;
    logic       div_start, div_done, div_err, sub_err;
    logic [7:0] mux_result, result;
    logic       busy, err, valid;

    int checks = 0;
    int errors = 0;

    calc_ctrl #(.BITS(8), .DIV_TIMEOUT(32)) dut (
        .clk16M(clk16M), .rst(rst), .sw(sw), .bt(bt),
        .a_op(a_op), .b_op(b_op), .op_sel(op_sel), .div_start(div_start),
        .div_done(div_done), .div_err(div_err), .sub_err(sub_err),
        .mux_result(mux_result), .result(result), .busy(busy), .err(err), .valid(valid)
    );

    always #5 clk16M = ~clk16M;

    // Datapath stand-in feeding the result multiplexer
    always_comb begin
        mux_result = 8'h00;
        case (op_sel)
            4'b0001: mux_result = {4'h0, a_op} + {4'h0, b_op};
            4'b0010: mux_result = {4'h0, a_op} - {4'h0, b_op};
            4'b0100: mux_result = {4'h0, a_op} * {4'h0, b_op};
            4'b1000: mux_result = (b_op != 0) ? {4'h0, a_op / b_op} : 8'h00;
            default: mux_result = 8'h00;
        endcase
        sub_err = op_sel[1] && (a_op < b_op);
    end

    typedef struct {
        logic [7:0] sw;
        logic [3:0] bt;
        int         dly;     // cycles from div_start to div_done, -1 = never
        logic       derr;
        logic [7:0] res;
        logic       er;
        logic [3:0] sel;
        int         lat;     // negedges from driving bt to seeing valid
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, output int lat, output int nds, output int nval);
        int ds_n;
        lat = -1; nds = 0; nval = 0; ds_n = -1;
        @(negedge clk16M);
        sw = v.sw;
        bt = v.bt;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk16M);
            if (n == 3) bt = 4'b0000;
            div_done = 1'b0;
            div_err  = 1'b0;
            if (div_start) begin nds++; ds_n = n; end
            if (valid) begin nval++; if (lat < 0) lat = n; end
            if (ds_n >= 0 && v.dly >= 0 && n == ds_n + v.dly) begin
                div_done = 1'b1;
                div_err  = v.derr;
            end
        end
    endtask

    initial begin
        int lat, nds, nval, seen;
        rst = 1'b1; sw = 8'h00; bt = 4'b0000; div_done = 1'b0; div_err = 1'b0;

        vecs[0]  = '{8'h35, 4'b0001, -1, 1'b0, 8'h08, 1'b0, 4'b0001, 5};
        vecs[1]  = '{8'h27, 4'b0010, -1, 1'b0, 8'hFF, 1'b1, 4'b0010, 5};
        vecs[2]  = '{8'h72, 4'b0010, -1, 1'b0, 8'h05, 1'b0, 4'b0010, 5};
        vecs[3]  = '{8'h34, 4'b0100, -1, 1'b0, 8'h0C, 1'b0, 4'b0100, 5};
        vecs[4]  = '{8'hFF, 4'b0100, -1, 1'b0, 8'hE1, 1'b0, 4'b0100, 5};
        vecs[5]  = '{8'hFF, 4'b0001, -1, 1'b0, 8'h1E, 1'b0, 4'b0001, 5};
        vecs[6]  = '{8'h93, 4'b1000,  9, 1'b0, 8'h03, 1'b0, 4'b1000, 13};
        vecs[7]  = '{8'h90, 4'b1000,  2, 1'b1, 8'hFF, 1'b1, 4'b1000, 6};
        vecs[8]  = '{8'h90, 4'b1000, -1, 1'b0, 8'hFF, 1'b1, 4'b1000, 36};
        vecs[9]  = '{8'h53, 4'b1010, -1, 1'b0, 8'h02, 1'b0, 4'b0010, 5};
        vecs[10] = '{8'h21, 4'b1111, -1, 1'b0, 8'h03, 1'b0, 4'b0001, 5};

        // Reset state
        repeat (3) @(negedge clk16M);
        chk("reset_outputs", {a_op, b_op, op_sel, result, err, valid, busy, div_start}, 32'h0);

        // Button held through reset release must not start an operation
        bt = 4'b0100;
        repeat (2) @(negedge clk16M);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk16M);
            if (busy || valid) seen++;
        end
        chk("held_btn_no_press", seen, 0);
        bt = 4'b0000;
        repeat (3) @(negedge clk16M);

        foreach (vecs[i]) begin
            run_op(vecs[i], lat, nds, nval);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_err", i), err, vecs[i].er);
            chk($sformatf("v%0d_op_sel", i), op_sel, vecs[i].sel);
            chk($sformatf("v%0d_a_op", i), a_op, vecs[i].sw[7:4]);
            chk($sformatf("v%0d_b_op", i), b_op, vecs[i].sw[3:0]);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_div_start_cnt", i), nds, vecs[i].sel[3] ? 1 : 0);
            chk($sformatf("v%0d_valid_cnt", i), nval, 1);
            chk($sformatf("v%0d_busy_idle", i), busy, 1'b0);
        end

        // Held values ignore later switch changes
        sw = 8'hAA;
        repeat (5) @(negedge clk16M);
        chk("hold_operands", {a_op, b_op}, 8'h21);
        chk("hold_result", {result, err}, {8'h03, 1'b0});

        // Press while busy in WAIT_DIV is dropped, not queued
        @(negedge clk16M);
        sw = 8'h84; bt = 4'b1000;
        lat = -1; nval = 0; seen = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk16M);
            if (n == 3)  bt = 4'b0000;
            if (n == 6)  bt = 4'b0001;
            if (n == 10) bt = 4'b0000;
            div_done = (n == 20);
            div_err  = 1'b0;
            if (n == 9 && busy) seen = 1;
            if (valid) begin nval++; if (lat < 0) lat = n; end
        end
        chk("busy_during_wait", seen, 1);
        chk("busy_press_op_sel", op_sel, 4'b1000);
        chk("busy_press_result", result, 8'h02);
        chk("busy_press_latency", lat, 21);
        chk("busy_press_not_queued", nval, 1);

        // Reset in WAIT_DIV aborts silently
        @(negedge clk16M);
        sw = 8'h91; bt = 4'b1000;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk16M);
            if (n == 3) bt = 4'b0000;
        end
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk16M);
        chk("abort_outputs", {a_op, b_op, op_sel, result, err, valid, busy, div_start}, 32'h0);
        rst = 1'b0;
        nds = 0; nval = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk16M);
            if (div_start) nds++;
            if (valid || busy) nval++;
        end
        chk("abort_no_div_start", nds, 0);
        chk("abort_no_activity", nval, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
